// File: rtl/spi_pkg.sv
// Shared constants for the SPI register link: frame layout, register map and
// controller state encoding.
package spi_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned RW_BIT   = 15;
  localparam int unsigned ADDR_MSB = 14;
  localparam int unsigned ADDR_LSB = 8;
  localparam logic        RW_WRITE = 1'b1;

  localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider. Phase restarts (high half first) while start is
// asserted; ticks mark the cycles in which the registered sclk will change.
module spi_sclk_gen #(
  parameter int unsigned SCLK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick,
  output logic low_end
);

  localparam int unsigned CW = $clog2(SCLK_HALF) + 1;

  logic [CW-1:0] cnt;
  logic          hi;
  logic          last;

  assign last = (cnt == CW'(SCLK_HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      hi  <= 1'b1;
    end else if (start) begin
      cnt <= '0;
      hi  <= 1'b1;
    end else if (en) begin
      if (last) begin
        cnt <= '0;
        hi  <= ~hi;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign sclk      = en & hi;
  assign rise_tick = en & hi & (cnt == '0);
  assign fall_tick = en & hi & last;
  assign low_end   = en & ~hi & last;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator, MSB first, 16-bit {rw, addr, data} frames, driven by a
// valid/ready command handshake.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 4,
  parameter int unsigned CS_SETUP  = 4,
  parameter int unsigned CS_HOLD   = 4,
  parameter int unsigned CS_IDLE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       copi,
  output logic       cs_n,
  input  logic       cipo
);

  state_t             state, next_state;
  logic [15:0]        tcnt;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] tx;
  logic [7:0]         rx;
  logic               accept;
  logic               sclk_lvl, rise_tick, fall_tick, low_end;
  logic               cs_n_d, sclk_d, copi_d, done_d, busy_d, ready_d;

  assign accept = cmd_valid & cmd_ready & (state == ST_IDLE);

  spi_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (state == ST_SETUP),
    .en        (state == ST_SHIFT),
    .sclk      (sclk_lvl),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .low_end   (low_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (accept)                          next_state = ST_SETUP;
      ST_SETUP: if (tcnt == 16'(CS_SETUP - 1))       next_state = ST_SHIFT;
      ST_SHIFT: if (low_end && bit_cnt == 4'd15)     next_state = ST_HOLD;
      ST_HOLD:  if (tcnt == 16'(CS_HOLD - 1))        next_state = ST_GAP;
      ST_GAP:   if (tcnt == 16'(CS_IDLE - 1))        next_state = ST_IDLE;
      default:                                       next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
    end else begin
      tcnt <= (next_state != state) ? '0 : tcnt + 16'd1;
      if (state == ST_SETUP)
        bit_cnt <= '0;
      else if (low_end)
        bit_cnt <= bit_cnt + 4'd1;
      if (accept) begin
        tx[RW_BIT]            <= cmd_rw;
        tx[ADDR_MSB:ADDR_LSB] <= cmd_addr;
        tx[7:0]               <= (cmd_rw == RW_WRITE) ? cmd_wdata : 8'h00;
      end else if (fall_tick && bit_cnt != 4'd15) begin
        tx <= {tx[FRAME_W-2:0], 1'b0};
      end
      // Only the last eight sampled bits (the data byte) survive in rx.
      if (rise_tick)
        rx <= {rx[6:0], cipo};
    end
  end

  // Output decode is registered below, so every pin lags the state by one clk.
  always_comb begin
    cs_n_d  = !(state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    sclk_d  = sclk_lvl;
    copi_d  = !cs_n_d & tx[RW_BIT];
    done_d  = (state == ST_GAP) && (tcnt == '0);
    ready_d = (next_state == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
      rdata     <= '0;
    end else begin
      cs_n      <= cs_n_d;
      sclk      <= sclk_d;
      copi      <= copi_d;
      done      <= done_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
      if (done_d)
        rdata <= rx;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: bus monitor plus a behavioural
// register-peripheral model, one task per scenario.
module tb_spi_controller;

  localparam int SH   = 4;
  localparam int CSS  = 4;
  localparam int CSH  = 4;
  localparam int CSI  = 4;
  localparam int LOW  = CSS + 2 * 16 * SH + CSH;
  localparam int LAT  = LOW + 1;
  localparam int LOW8 = CSS + 2 * 16 * 8 + CSH;

  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cipo = 1'b0;
  logic       cmd_ready, busy, done, sclk, copi, cs_n;
  logic [7:0] rdata;

  logic       cmd_valid8 = 1'b0, cipo8 = 1'b0;
  logic       cmd_ready8, busy8, done8, sclk8, copi8, cs_n8;
  logic [7:0] rdata8;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;

  spi_controller u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .sclk(sclk), .copi(copi), .cs_n(cs_n), .cipo(cipo)
  );

  spi_controller #(.SCLK_HALF(8)) u_dut8 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .busy(busy8), .done(done8), .rdata(rdata8),
    .sclk(sclk8), .copi(copi8), .cs_n(cs_n8), .cipo(cipo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and peripheral model: frames commit only if all 16 bits arrived.
  logic [15:0] frames[$];
  int          lows[$];
  int          gaps[$];
  logic [7:0]  regs [128] = '{default: 8'h00};
  logic [7:0]  drive_byte = 8'h00;
  logic [15:0] shreg = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int          rises = 0, falls = 0, low_len = 0, high_len = 1000;

  always @(negedge clk) begin
    if (!cs_n) begin
      if (prev_cs) begin
        gaps.push_back(high_len);
        low_len = 0; rises = 0; falls = 0; cipo = 1'b0;
      end
      low_len++;
      if (sclk && !prev_sclk) begin
        shreg = {shreg[14:0], copi};
        rises++;
      end
      if (!sclk && prev_sclk) begin
        falls++;
        cipo = (falls >= 8 && falls < 16) ? drive_byte[3'(15 - falls)] : 1'b0;
      end
    end else begin
      if (!prev_cs) begin
        if (rises == 16) begin
          frames.push_back(shreg);
          lows.push_back(low_len);
          if (shreg[15]) regs[shreg[14:8]] = shreg[7:0];
        end
        high_len = 0;
        cipo = 1'b0;
      end
      high_len++;
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  task automatic start_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d,
                           output int acc, output bit to);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    to = !cmd_ready;
    @(posedge clk);
    #1 acc = cyc;
  endtask

  task automatic wait_done(output int dc, output bit to);
    to = 1'b1;
    dc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs_n, sclk, copi, busy, done, cmd_ready, rdata} !== {6'b100000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b",
               {cs_n, sclk, copi, busy, done, cmd_ready, rdata}, {6'b100000, 8'h00});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_write_duty();
    int acc, dc, nf;
    bit to1, to2;
    drive_byte = 8'($urandom);
    nf = frames.size();
    start_cmd(1'b1, 7'h04, 8'h80, acc, to1);
    @(negedge clk); cmd_valid = 1'b0;
    wait_done(dc, to2);
    n_checks++;
    if (to1 || to2) begin n_fail++; $display("FAIL duty_timeout: got %b%b expected 00", to1, to2); end
    n_checks++;
    if (dc - acc !== LAT) begin n_fail++; $display("FAIL duty_latency: got %0d expected %0d", dc - acc, LAT); end
    n_checks++;
    if (rdata !== drive_byte) begin n_fail++; $display("FAIL duty_rdata: got %h expected %h", rdata, drive_byte); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", done); end
    n_checks++;
    if (frames.size() !== nf + 1 || frames[$] !== 16'h8480) begin
      n_fail++; $display("FAIL duty_frame: got %h expected 8480", frames[$]);
    end
    n_checks++;
    if (lows[$] !== LOW) begin n_fail++; $display("FAIL duty_cs_low: got %0d expected %0d", lows[$], LOW); end
    n_checks++;
    if (regs[4] !== 8'h80) begin n_fail++; $display("FAIL duty_reg: got %h expected 80", regs[4]); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, dc;
    bit to1, to2, to3;
    drive_byte = 8'($urandom);
    start_cmd(1'b1, 7'h00, 8'hFF, acc1, to1);
    start_cmd(1'b1, 7'h02, 8'h0F, acc2, to2);
    @(negedge clk); cmd_valid = 1'b0;
    wait_done(dc, to3);
    @(negedge clk);
    n_checks++;
    if (to1 || to2 || to3) begin n_fail++; $display("FAIL b2b_timeout: got %b%b%b expected 000", to1, to2, to3); end
    n_checks++;
    if (acc2 - acc1 < LAT + CSI) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d expected >= %0d", acc2 - acc1, LAT + CSI);
    end
    n_checks++;
    if (gaps[$] < CSI) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d expected >= %0d", gaps[$], CSI); end
    n_checks++;
    if (frames.size() < 2 || frames[$-1] !== 16'h80FF || frames[$] !== 16'h820F) begin
      n_fail++; $display("FAIL b2b_frames: got %h %h expected 80ff 820f", frames[$-1], frames[$]);
    end
    n_checks++;
    if (regs[0] !== 8'hFF || regs[2] !== 8'h0F) begin
      n_fail++; $display("FAIL b2b_regs: got %h %h expected ff 0f", regs[0], regs[2]);
    end
  endtask

  task automatic test_read();
    int acc, dc;
    bit to1, to2;
    logic [6:0] a;
    for (int k = 0; k < 2; k++) begin
      drive_byte = (k == 0) ? 8'hA5 : 8'($urandom);
      a = (k == 0) ? 7'h00 : 7'($urandom);
      start_cmd(1'b0, a, 8'($urandom), acc, to1);
      @(negedge clk); cmd_valid = 1'b0;
      wait_done(dc, to2);
      n_checks++;
      if (to1 || to2 || rdata !== drive_byte) begin
        n_fail++; $display("FAIL read_rdata[%0d]: got %h expected %h", k, rdata, drive_byte);
      end
      @(negedge clk);
      n_checks++;
      if (frames[$] !== {1'b0, a, 8'h00}) begin
        n_fail++; $display("FAIL read_frame[%0d]: got %h expected %h", k, frames[$], {1'b0, a, 8'h00});
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, dc, nf, r, bad;
    bit to1, to2, done_seen;
    logic p;
    logic [7:0] snap [128];
    snap = regs;
    nf = frames.size();
    drive_byte = 8'($urandom);
    start_cmd(1'b1, 7'h03, 8'h77, acc, to1);
    @(negedge clk); cmd_valid = 1'b0;
    r = 0; p = sclk;
    for (int i = 0; i < 300 && r < 5; i++) begin
      @(negedge clk);
      if (sclk && !p) r++;
      p = sclk;
    end
    n_checks++;
    if (to1 || r != 5) begin n_fail++; $display("FAIL mid_reach_rise5: got %0d expected 5", r); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cs_n, sclk, copi, busy, done} !== 5'b10000) begin
      n_fail++; $display("FAIL mid_async_reset: got %b expected 10000", {cs_n, sclk, copi, busy, done});
    end
    done_seen = 1'b0;
    repeat (2) begin @(negedge clk); done_seen |= done; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); done_seen |= done; end
    n_checks++;
    if (done_seen !== 1'b0 || frames.size() !== nf) begin
      n_fail++; $display("FAIL mid_no_done: got done=%b frames=%0d expected done=0 frames=%0d",
                         done_seen, frames.size(), nf);
    end
    start_cmd(1'b1, 7'h01, 8'h3C, acc, to1);
    @(negedge clk); cmd_valid = 1'b0;
    wait_done(dc, to2);
    @(negedge clk);
    n_checks++;
    if (to1 || to2 || regs[1] !== 8'h3C) begin
      n_fail++; $display("FAIL mid_followup_reg: got %h expected 3c", regs[1]);
    end
    bad = 0;
    for (int i = 0; i < 128; i++) if (i != 1 && regs[i] !== snap[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mid_other_regs: got %0d changed expected 0", bad); end
  endtask

  task automatic test_scramble();
    int acc, bad;
    bit to1, to2;
    logic [6:0] a;
    logic [7:0] d;
    a = 7'($urandom); d = 8'($urandom);
    drive_byte = 8'($urandom);
    start_cmd(1'b1, a, d, acc, to1);
    @(negedge clk); cmd_valid = 1'b0;
    bad = 0; to2 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin to2 = 1'b0; break; end
      if (busy && cmd_ready) bad++;
      cmd_rw = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
    end
    @(negedge clk);
    n_checks++;
    if (to1 || to2 || bad != 0) begin
      n_fail++; $display("FAIL scramble_ready: got %0d ready-while-busy cycles expected 0", bad);
    end
    n_checks++;
    if (frames[$] !== {1'b1, a, d}) begin
      n_fail++; $display("FAIL scramble_frame: got %h expected %h", frames[$], {1'b1, a, d});
    end
  endtask

  task automatic test_random();
    int acc, dc;
    bit to1, to2;
    logic rw;
    logic [6:0] a;
    logic [7:0] d;
    logic [15:0] exp;
    for (int k = 0; k < 6; k++) begin
      rw = 1'($urandom); a = 7'($urandom); d = 8'($urandom);
      drive_byte = 8'($urandom);
      exp = {rw, a, rw ? d : 8'h00};
      start_cmd(rw, a, d, acc, to1);
      @(negedge clk); cmd_valid = 1'b0;
      wait_done(dc, to2);
      n_checks++;
      if (to1 || to2 || dc - acc !== LAT) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, dc - acc, LAT);
      end
      n_checks++;
      if (rdata !== drive_byte) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", k, rdata, drive_byte);
      end
      @(negedge clk);
      n_checks++;
      if (frames[$] !== exp || lows[$] !== LOW) begin
        n_fail++; $display("FAIL rand_frame[%0d]: got %h/%0d expected %h/%0d", k, frames[$], lows[$], exp, LOW);
      end
    end
  endtask

  task automatic test_slow();
    int acc, dc, low8, n;
    bit to;
    @(negedge clk);
    cmd_valid8 = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h04; cmd_wdata = 8'h55;
    n = 0;
    while (!cmd_ready8 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk); cmd_valid8 = 1'b0;
    low8 = cs_n8 ? 0 : 1;
    to = 1'b1; dc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done8) begin dc = cyc; to = 1'b0; break; end
      if (!cs_n8) low8++;
    end
    n_checks++;
    if (to || low8 !== LOW8) begin n_fail++; $display("FAIL slow_cs_low: got %0d expected %0d", low8, LOW8); end
    n_checks++;
    if (dc - acc !== LOW8 + 1) begin n_fail++; $display("FAIL slow_latency: got %0d expected %0d", dc - acc, LOW8 + 1); end
  endtask

  initial begin
    test_reset();
    test_write_duty();
    test_back_to_back();
    test_read();
    test_reset_mid();
    test_scramble();
    test_random();
    test_slow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
